// File: rtl/fetch_unit_harvard.sv
// Harvard instruction fetch stage: one-deep output register with valid/ready, redirect and optional halt.
// Optional feature: define FETCH_HALT_ON_ZERO_EN to halt fetch on an all-zero instruction word.
module fetch_unit_harvard #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        halted_q, halted_d;
  logic        slot_free;
  logic        zero_halt;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_halt = (instr_readdata == 32'h0000_0000);
`else
  assign zero_halt = 1'b0;
`endif

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    // Redirect wins in every state; a coincident handshake already completed.
    if (redirect_valid) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (slot_free) begin
            if (zero_halt) begin
              out_valid_d = 1'b0;
              state_d     = ST_HALTED;
            end else begin
              out_instr_d = instr_readdata;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              pc_d        = pc_q + 32'd4;
            end
          end
        end
        ST_HALTED: begin
          if (out_ready) out_valid_d = 1'b0;
        end
        default: state_d = ST_RUN;
      endcase
    end
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      halted_q    <= halted_d;
    end
  end

  assign instr_address = pc_q;
  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_pc        = out_pc_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_unit_harvard.sv
// Bench for fetch_unit_harvard: directed scenarios then randomized valid/ready/redirect traffic vs a stream model.
module tb_fetch_unit_harvard;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0] mem [0:63];
  int tests  = 0;
  int failed = 0;

  fetch_unit_harvard #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Small aliased instruction RAM, read combinationally.
  assign instr_readdata = mem[instr_address[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream model state: next address to fetch and the presented slot.
  logic [31:0] m_fetch, m_opc, m_oi;
  logic        m_valid;
  logic        rv_in, rdy_in;
  logic [31:0] rp_in;

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'hAC41_000A;
    mem[1]  = 32'h8C43_000A;
    mem[2]  = 32'h0000_0000;
    mem[63] = 32'hDEAD_BEEF;

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_addr", instr_address, RV);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    // First two fetches back to back.
    @(negedge clk);
    check("c1_instr", out_instr, 32'hAC41_000A);
    check("c1_pc", out_pc, 32'h0);
    check("c1_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    check("c2_instr", out_instr, 32'h8C43_000A);
    check("c2_pc", out_pc, 32'h4);
    check("c2_addr", instr_address, 32'h8);

    // Back-pressure: hold AC41000A for three cycles.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    check("rd0_valid", {31'b0, out_valid}, 32'd0);
    check("rd0_addr", instr_address, 32'h0);
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("st_load_instr", out_instr, 32'hAC41_000A);
    for (int k = 0; k < 3; k++) begin
      check("st_instr", out_instr, 32'hAC41_000A);
      check("st_pc", out_pc, 32'h0);
      check("st_valid", {31'b0, out_valid}, 32'd1);
      check("st_addr", instr_address, 32'h4);
      @(negedge clk);
    end
    check("st_end_instr", out_instr, 32'hAC41_000A);
    out_ready = 1'b1;
    @(negedge clk);
    check("st_next_instr", out_instr, 32'h8C43_000A);
    check("st_next_pc", out_pc, 32'h4);
    check("st_next_addr", instr_address, 32'h8);

    // Misaligned redirect while an instruction is presented.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0006;
    @(negedge clk);
    check("rd6_valid", {31'b0, out_valid}, 32'd0);
    check("rd6_addr", instr_address, 32'h4);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd6_pc", out_pc, 32'h4);
    check("rd6_instr", out_instr, 32'h8C43_000A);

`ifdef FETCH_HALT_ON_ZERO_EN
    @(negedge clk);
    check("hz_halted", {31'b0, halted}, 32'd1);
    check("hz_valid", {31'b0, out_valid}, 32'd0);
    check("hz_addr", instr_address, 32'h8);
    @(negedge clk);
    check("hz_hold_addr", instr_address, 32'h8);
    check("hz_hold_halted", {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    @(negedge clk);
    check("hz_unhalt", {31'b0, halted}, 32'd0);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("hz_resume_instr", out_instr, 32'hAC41_000A);
    check("hz_resume_pc", out_pc, 32'h0);
`else
    @(negedge clk);
    check("z_instr", out_instr, 32'h0);
    check("z_pc", out_pc, 32'h8);
    check("z_valid", {31'b0, out_valid}, 32'd1);
    check("z_halted", {31'b0, halted}, 32'd0);
`endif

    // Address wrap at the top of the space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wr_addr", instr_address, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wr_pc_top", out_pc, 32'hFFFF_FFFC);
    check("wr_instr_top", out_instr, 32'hDEAD_BEEF);
    check("wr_addr_wrap", instr_address, 32'h0);
    @(negedge clk);
    check("wr_pc_zero", out_pc, 32'h0);
    check("wr_instr_zero", out_instr, 32'hAC41_000A);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_addr", instr_address, RV);
    check("ar_pc", out_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_resume_pc", out_pc, RV);
    check("ar_resume_valid", {31'b0, out_valid}, 32'd1);
    check("ar_resume_instr", out_instr, 32'hAC41_000A);

    // Randomized traffic; RAM content kept nonzero so both builds share one model.
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    redirect_valid = 1'b1;
    redirect_pc = $urandom;
    m_fetch = {redirect_pc[31:2], 2'b00};
    m_valid = 1'b0;
    m_opc = 32'h0;
    m_oi = 32'h0;
    @(negedge clk);
    check("rnd_sync_addr", instr_address, m_fetch);
    check("rnd_sync_valid", {31'b0, out_valid}, 32'd0);
    for (int n = 0; n < 400; n++) begin
      rv_in  = ($urandom_range(0, 7) == 0);
      rdy_in = ($urandom_range(0, 2) != 0);
      rp_in  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      redirect_valid = rv_in;
      redirect_pc = rp_in;
      out_ready = rdy_in;
      @(negedge clk);
      if (rv_in) begin
        m_fetch = {rp_in[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (!m_valid || rdy_in) begin
        m_opc   = m_fetch;
        m_oi    = mem[m_fetch[7:2]];
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd4;
      end
      check("rnd_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("rnd_addr", instr_address, m_fetch);
      check("rnd_halted", {31'b0, halted}, 32'd0);
      if (m_valid) begin
        check("rnd_pc", out_pc, m_opc);
        check("rnd_instr", out_instr, m_oi);
      end
    end
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit_harvard.md
FETCH_UNIT_HARVARD -- requirements
Module: fetch_unit_harvard

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: instr_address  out  32  byte address driven to the instruction RAM; always equals internal pc.
REQ-005 SHALL have port: instr_readdata  in  32  big-endian word returned combinationally by the instruction RAM for instr_address.
REQ-006 SHALL have port: out_valid  out  1  out_instr/out_pc hold a fetched instruction.
REQ-007 SHALL have port: out_ready  in  1  downstream accepts the instruction this cycle.
REQ-008 SHALL have port: out_instr  out  32  fetched instruction word.
REQ-009 SHALL have port: out_pc  out  32  address the instruction was fetched from.
REQ-010 SHALL have port: redirect_valid  in  1  branch/jump redirect request.
REQ-011 SHALL have port: redirect_pc  in  32  redirect target.
REQ-012 SHALL have port: halted  out  1  fetch unit in HALTED state.

Function
REQ-013 SHALL implement states RUN and HALTED; after reset state is RUN.
REQ-014 SHALL define slot_free = !out_valid || out_ready, evaluated each cycle.
REQ-015 SHALL, in RUN with slot_free and no redirect, on the clock edge: out_instr<=instr_readdata, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-016 SHALL, in RUN with !slot_free and no redirect, hold pc, out_instr, out_pc, out_valid unchanged (no dropped or duplicated instruction).
REQ-017 SHALL give latency of exactly one cycle from pc driven to out_valid, sustaining one instruction per cycle while out_ready=1.
REQ-018 SHALL give redirect_valid priority over all other events in any state: pc<=redirect_pc with bits[1:0] forced to 0, out_valid<=0 (pending instruction flushed), state<=RUN.
REQ-019 SHALL treat an out_valid&&out_ready handshake coincident with redirect_valid as a completed transfer; the flushed value is the one not yet presented.
REQ-020 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000, no flag).
REQ-021 SHALL, in HALTED, hold pc, keep out_valid cleared once current output handshakes, assert halted=1, and issue no new fetch until redirect_valid.
REQ-022 SHALL drive halted=1 only in HALTED, else 0.

Reset
REQ-023 SHALL, on reset assertion, immediately and asynchronously set pc=RESET_VECTOR, out_valid=0, out_instr=0, out_pc=0, state=RUN, halted=0.
REQ-024 SHALL discard any in-flight instruction on reset mid-operation; first fetch after deassertion is RESET_VECTOR.

Configuration
REQ-025 SHALL, with FETCH_HALT_ON_ZERO_EN defined, on a RUN fetch returning 32'h0000_0000 with slot_free: not present the word (out_valid<=0), hold pc at that address, enter HALTED.
REQ-026 SHALL, without FETCH_HALT_ON_ZERO_EN, treat 32'h0000_0000 as an ordinary instruction per REQ-015; HALTED unreachable, halted constantly 0.

Verification
REQ-027 SHALL cover: RAM bytes 0..7 = AC 41 00 0A 8C 43 00 0A, out_ready=1 after reset -> cycle 1 out_instr=32'hAC41000A/out_pc=0, cycle 2 out_instr=32'h8C43000A/out_pc=4, instr_address=8.
REQ-028 SHALL cover: out_ready=0 for 3 cycles while out_instr=32'hAC41000A -> outputs and instr_address=4 stable; first out_ready=1 -> next out_instr=32'h8C43000A, nothing skipped.
REQ-029 SHALL cover: redirect_valid=1, redirect_pc=32'h0000_0006 while out_valid=1 -> next cycle out_valid=0, instr_address=4; following cycle out_pc=4.
REQ-030 SHALL cover: with FETCH_HALT_ON_ZERO_EN, fetch at address 8 returns 0 -> halted=1, out_valid=0, instr_address=8 held; redirect_pc=0 -> halted=0, out_instr=32'hAC41000A next; without macro -> out_instr=0, out_pc=8, no halt.
REQ-031 SHALL cover: redirect_pc=32'hFFFF_FFFC, out_ready=1 -> out_pc=32'hFFFF_FFFC then out_pc=0.
REQ-032 SHALL cover: reset asserted mid-stream between clock edges -> out_valid=0 and instr_address=RESET_VECTOR before next edge; resumes at RESET_VECTOR.
